adc_frame_serializer: RTL and testbench

ADC_FRAME_SERIALIZER -- requirements
Module: adc_frame_serializer

---
 rtl/adc_frame_serializer_pkg.sv | 15 +
 rtl/adc_lane_shifter.sv | 25 ++
 rtl/adc_frame_serializer.sv | 123 ++++++++++++
 tb/tb_adc_frame_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_serializer_pkg.sv
// Shared types and helpers for the ADC frame serializer.
// Holds the FSM state type and the per-lane bit-count function.
package my_utils;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_e;

  // Bits each lane shifts out per frame.
  function automatic int lane_bits(int n_ch, int word_w, int n_lanes);
    return (n_ch / n_lanes) * word_w;
  endfunction

endpackage

// File: rtl/adc_lane_shifter.sv
// One serial lane: parallel load, MSB-first shift, zero fill.
// Once a frame has been shifted out, the register holds zeros.
module adc_lane_shifter #(
  parameter int B_W = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           load_i,
  input  logic [B_W-1:0] data_i,
  output logic           dout_o
);

  logic [B_W-1:0] sh_q;

  // Clear wins over load, so an aborted frame leaves no residue.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) sh_q <= '0;
    else if (load_i)    sh_q <= data_i;
    else                sh_q <= sh_q << 1;
  end

  assign dout_o = sh_q[B_W-1];

endmodule

// File: rtl/adc_frame_serializer.sv
// Frame-based serializer: N_CH sample words onto N_LANES lanes.
// A frame starts every FRAME_PERIOD cycles; nSYNC_IN restarts it.
module adc_frame_serializer
  import my_utils::*;
#(
  parameter int N_CH         = 8,
  parameter int WORD_W       = 32,
  parameter int N_LANES      = 4,
  parameter int FRAME_PERIOD = 128
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               nSYNC_IN,
  input  logic [WORD_W-1:0]  NEXT_DATA [N_CH],
  input  logic               NEXT_VALID,
  output logic               NEXT_READY,
  output logic [N_LANES-1:0] DOUT,
  output logic               nDRDY,
  output logic               STALE
);

  localparam int B   = lane_bits(N_CH, WORD_W, N_LANES);
  localparam int CPL = N_CH / N_LANES;
  localparam int FW  = $clog2(FRAME_PERIOD);

  localparam logic [FW-1:0] B_CNT = FW'(B);
  localparam logic [FW-1:0] LAST  = FW'(FRAME_PERIOD - 1);

  if (N_CH % N_LANES != 0) begin : g_bad_lanes
    $error("N_CH must be a multiple of N_LANES");
  end
  if (FRAME_PERIOD < B + 2) begin : g_bad_period
    $error("FRAME_PERIOD too short for lane bit count");
  end

  state_e          st_q;
  logic [FW-1:0]   fcnt_q;
  logic            ready_q;
  logic            ndrdy_q;
  logic            stale_q;
  logic [WORD_W-1:0] shadow_q [N_CH];

  logic at0;
  logic abort;
  logic [WORD_W-1:0] src_d  [N_CH];
  logic [B-1:0]      lane_d [N_LANES];

  assign at0   = (st_q == RUN) && (fcnt_q == '0);
  assign abort = (st_q == RUN) && !nSYNC_IN;

  // Pick fresh or repeated samples and pack each lane MSB-first.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      src_d[c] = NEXT_VALID ? NEXT_DATA[c] : shadow_q[c];
    end
    for (int l = 0; l < N_LANES; l++) begin
      lane_d[l] = '0;
      for (int j = 0; j < CPL; j++) begin
        lane_d[l][B-1-j*WORD_W -: WORD_W] = src_d[l+j*N_LANES];
      end
    end
  end

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q     <= SYNC_WAIT;
      fcnt_q   <= '0;
      ready_q  <= 1'b0;
      ndrdy_q  <= 1'b1;
      stale_q  <= 1'b0;
      shadow_q <= '{default: '0};
    end else begin
      ready_q <= 1'b0;
      ndrdy_q <= 1'b1;
      if (at0) begin
        if (NEXT_VALID) shadow_q <= NEXT_DATA;
        stale_q <= !NEXT_VALID;
      end
      unique case (st_q)
        SYNC_WAIT: begin
          fcnt_q <= '0;
          if (nSYNC_IN) begin
            st_q    <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (!nSYNC_IN) begin
            st_q   <= SYNC_WAIT;
            fcnt_q <= '0;
          end else begin
            if (fcnt_q == LAST) begin
              fcnt_q  <= '0;
              ready_q <= 1'b1;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
            ndrdy_q <= !(fcnt_q < B_CNT);
          end
        end
      endcase
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    adc_lane_shifter #(
      .B_W (B)
    ) u_shift (
      .clk_i  (CLK),
      .rst_i  (RST),
      .clr_i  (abort),
      .load_i (at0),
      .data_i (lane_d[l]),
      .dout_o (DOUT[l])
    );
  end

  assign NEXT_READY = ready_q;
  assign nDRDY      = ndrdy_q;
  assign STALE      = stale_q;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Bench for adc_frame_serializer: four lane configurations
// against a frame-level model plus literal frame checks.
module tb_adc_frame_serializer;

  localparam int NCH = 8;
  localparam int W   = 32;
  localparam int NG  = 4;

  logic clk = 1'b0;
  logic rst;
  logic nsync;
  logic valid;
  logic [W-1:0] data [NCH];
  logic [10:0]  act  [NG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    localparam int P = (g == 0) ? 128 : 260;
    logic [L-1:0] dout;
    logic rdy;
    logic ndrdy;
    logic stale;
    adc_frame_serializer #(
      .N_CH         (NCH),
      .WORD_W       (W),
      .N_LANES      (L),
      .FRAME_PERIOD (P)
    ) u_dut (
      .CLK        (clk),
      .RST        (rst),
      .nSYNC_IN   (nsync),
      .NEXT_DATA  (data),
      .NEXT_VALID (valid),
      .NEXT_READY (rdy),
      .DOUT       (dout),
      .nDRDY      (ndrdy),
      .STALE      (stale)
    );
    assign act[g] = {rdy, ndrdy, stale, 8'(dout)};
  end

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  bit           m_run   [NG];
  int           m_cnt   [NG];
  bit           m_stale [NG];
  logic [W-1:0] m_sh    [NG][NCH];
  logic [W-1:0] m_fr    [NG][NCH];

  function automatic int lanes(int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
  endfunction

  function automatic int period(int g);
    return (g == 0) ? 128 : 260;
  endfunction

  task automatic model_edge();
    for (int g = 0; g < NG; g++) begin
      if (rst) begin
        m_run[g]   = 1'b0;
        m_cnt[g]   = 0;
        m_stale[g] = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          m_sh[g][c] = '0;
          m_fr[g][c] = '0;
        end
      end else if (!m_run[g]) begin
        if (nsync) begin
          m_run[g] = 1'b1;
          m_cnt[g] = 0;
        end
      end else begin
        if (m_cnt[g] == 0) begin
          if (valid)
            for (int c = 0; c < NCH; c++) m_sh[g][c] = data[c];
          m_stale[g] = !valid;
          for (int c = 0; c < NCH; c++) m_fr[g][c] = m_sh[g][c];
        end
        if (!nsync) begin
          m_run[g] = 1'b0;
          m_cnt[g] = 0;
        end else begin
          m_cnt[g] = (m_cnt[g] + 1) % period(g);
        end
      end
    end
    if (rst) armed = 1'b1;
  endtask

  function automatic logic [10:0] expect_of(int g);
    int b = (NCH / lanes(g)) * W;
    int k = m_cnt[g];
    logic on = m_run[g] && (k >= 1) && (k <= b);
    logic [7:0] d = '0;
    if (on) begin
      for (int l = 0; l < lanes(g); l++) begin
        int ch = l + ((k - 1) / W) * lanes(g);
        int bi = W - 1 - ((k - 1) % W);
        d[l] = m_fr[g][ch][bi];
      end
    end
    return {m_run[g] && (k == 0), !on, m_stale[g], d};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (armed) begin
      for (int g = 0; g < NG; g++) begin
        logic [10:0] e;
        e = expect_of(g);
        n_chk++;
        if (act[g] !== e) begin
          n_fail++;
          $display("FAIL model_cfg%0d (lanes=%0d) t=%0t: got %h expected %h",
                   g, lanes(g), $time, act[g], e);
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  initial begin
    logic [63:0] cap;
    logic [63:0] c0, c1, c2, c3;
    logic        any;
    int          lo;

    rst = 1'b1; nsync = 1'b0; valid = 1'b0;
    for (int c = 0; c < NCH; c++) data[c] = '0;
    repeat (100) tick();
    chk("reset_outputs", 64'(act[0]), 64'h200);

    data[0] = 32'hA5A5A5A5; data[4] = 32'h0F0F0F0F;
    valid = 1'b1; rst = 1'b0; nsync = 1'b1;
    tick();
    chk("ready_at_fcnt0", 64'(act[0][10]), 64'd1);
    tick();
    valid = 1'b0;
    for (int c = 0; c < NCH; c++) data[c] = $urandom();
    cap = '0; lo = 0;
    for (int k = 0; k < 64; k++) begin
      cap = {cap[62:0], act[0][0]};
      lo += int'(!act[0][9]);
      tick();
    end
    chk("lane0_frame1", cap, 64'hA5A5A5A50F0F0F0F);
    chk("ndrdy_low_cycles", 64'(lo), 64'd64);
    chk("ndrdy_high_fcnt65", 64'(act[0][9]), 64'd1);
    repeat (63) tick();
    chk("ready_period_128", 64'(act[0][10]), 64'd1);
    tick();
    chk("stale_frame2", 64'(act[0][8]), 64'd1);
    cap = '0;
    for (int k = 0; k < 64; k++) begin
      cap = {cap[62:0], act[0][0]};
      tick();
    end
    chk("lane0_frame2_repeat", cap, 64'hA5A5A5A50F0F0F0F);
    valid = 1'b1; data[0] = 32'h92345678;
    repeat (63) tick();
    tick();
    chk("stale_frame3", 64'(act[0][8]), 64'd0);
    chk("lane0_msb_frame3", 64'(act[0][0]), 64'd1);

    repeat (29) tick();
    nsync = 1'b0;
    tick();
    chk("abort_ndrdy", 64'(act[0][9]), 64'd1);
    chk("abort_dout", 64'(act[0][3:0]), 64'd0);
    nsync = 1'b1;
    tick();
    chk("resync_ready", 64'(act[0][10]), 64'd1);

    repeat (40) tick();
    rst = 1'b1;
    tick(); tick();
    chk("rst_midframe", 64'(act[0]), 64'h200);
    valid = 1'b0; rst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(act[0][10]), 64'd1);
    tick();
    chk("stale_after_rst", 64'(act[0][8]), 64'd1);
    any = 1'b0;
    for (int k = 0; k < 64; k++) begin
      any |= |act[0][3:0];
      tick();
    end
    chk("shadow_cleared", 64'(any), 64'd0);

    for (int c = 0; c < NCH; c++) data[c] = 32'h1000_0000 * c + c;
    valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    c0 = '0; c1 = '0; c2 = '0; c3 = '0;
    for (int k = 0; k < 64; k++) begin
      c0 = {c0[62:0], act[0][3]};
      c1 = {c1[62:0], act[1][0]};
      c2 = {c2[62:0], act[2][1]};
      c3 = {c3[62:0], act[3][5]};
      tick();
    end
    chk("sweep_l4_lane3", c0, 64'h3000000370000007);
    chk("sweep_l1_lane0", c1, 64'h0000000010000001);
    chk("sweep_l2_lane1", c2, 64'h1000000130000003);
    chk("sweep_l8_lane5", c3, 64'h5000000500000000);
    repeat (600) tick();

    for (int i = 0; i < 6000; i++) begin
      valid = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0)
        for (int c = 0; c < NCH; c++) data[c] = $urandom();
      nsync = ($urandom_range(150) != 0);
      rst   = ($urandom_range(2000) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
